// File: rtl/rom_fetch_arbiter.sv
// Arbitrates the byte-wide combinational ROM between the fetch and load ports,
// assembling each request little-endian from single-byte reads.
module rom_fetch_arbiter #(
  parameter int unsigned DATA_BYTES_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  output logic        if_error,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_size,
  output logic        ld_ready,
  output logic [31:0] ld_data,
  output logic        ld_error,
  output logic        busy,
  output logic [31:0] rom_address,
  input  logic [7:0]  rom_read_data,
  input  logic        rom_illegal_address
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

  localparam logic [1:0] FETCH_LAST = 2'(DATA_BYTES_MAX - 1);

  state_t      state_q;
  logic [31:0] base_q;
  logic [31:0] data_q;
  logic [31:0] rom_address_q;
  logic [1:0]  idx_q;
  logic [1:0]  last_idx_q;
  logic        grant_ld_q;
  logic        last_ld_q;
  logic        err_q;
  logic        if_ready_q, ld_ready_q;
  logic        if_error_q, ld_error_q;
  logic        busy_q;

  logic        grant_ld_d;
  logic [1:0]  last_idx_d;
  logic [31:0] data_d;
  logic        err_d;

  always_comb begin
    grant_ld_d = ld_req;
    // Tie goes to whoever was not served last.
    if (if_req && ld_req) grant_ld_d = ~last_ld_q;

    last_idx_d = FETCH_LAST;
    if (grant_ld_d) begin
      case (ld_size)
        2'd0:    last_idx_d = 2'd0;
        2'd1:    last_idx_d = 2'd1;
        default: last_idx_d = 2'd3;
      endcase
    end

    data_d = data_q;
    for (int unsigned b = 0; b < 4; b++) begin
      if (idx_q == 2'(b)) data_d[8*b +: 8] = rom_read_data;
    end

    err_d = err_q | rom_illegal_address;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      data_q        <= '0;
      rom_address_q <= '0;
      idx_q         <= '0;
      last_idx_q    <= '0;
      grant_ld_q    <= 1'b0;
      last_ld_q     <= 1'b1;
      err_q         <= 1'b0;
      if_ready_q    <= 1'b0;
      ld_ready_q    <= 1'b0;
      if_error_q    <= 1'b0;
      ld_error_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (if_req || ld_req) begin
            grant_ld_q <= grant_ld_d;
            base_q     <= grant_ld_d ? ld_addr : if_addr;
            idx_q      <= '0;
            data_q     <= '0;
            busy_q     <= 1'b1;
            if (grant_ld_d && ld_size == 2'd3) begin
              err_q      <= 1'b1;
              ld_ready_q <= 1'b1;
              ld_error_q <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              err_q         <= 1'b0;
              last_idx_q    <= last_idx_d;
              rom_address_q <= grant_ld_d ? ld_addr : if_addr;
              state_q       <= S_READ;
            end
          end
        end
        S_READ: begin
          data_q <= data_d;
          err_q  <= err_d;
          if (idx_q == last_idx_q) begin
            rom_address_q <= '0;
            state_q       <= S_DONE;
            if (grant_ld_q) begin
              ld_ready_q <= 1'b1;
              ld_error_q <= err_d;
            end else begin
              if_ready_q <= 1'b1;
              if_error_q <= err_d;
            end
          end else begin
            idx_q         <= idx_q + 2'd1;
            rom_address_q <= base_q + 32'(idx_q) + 32'd1;
          end
        end
        S_DONE: begin
          if_ready_q <= 1'b0;
          ld_ready_q <= 1'b0;
          if_error_q <= 1'b0;
          ld_error_q <= 1'b0;
          busy_q     <= 1'b0;
          idx_q      <= '0;
          last_ld_q  <= grant_ld_q;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_ready    = if_ready_q;
  assign ld_ready    = ld_ready_q;
  assign if_error    = if_error_q;
  assign ld_error    = ld_error_q;
  assign if_data     = data_q;
  assign ld_data     = data_q;
  assign busy        = busy_q;
  assign rom_address = rom_address_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Self-checking bench for rom_fetch_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level model of the ROM sequencer.
module tb_rom_fetch_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, ld_req;
  logic [31:0] if_addr, ld_addr;
  logic [1:0]  ld_size;
  logic        if_ready, ld_ready, if_error, ld_error, busy;
  logic [31:0] if_data, ld_data, rom_address;
  logic [7:0]  rom_read_data;
  logic        rom_illegal_address;

  logic [7:0]  mem [0:4095];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rom_illegal_address = (rom_address >= 32'd4096);
  assign rom_read_data       = rom_illegal_address ? 8'h00 : mem[rom_address[11:0]];

  rom_fetch_arbiter #(.DATA_BYTES_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data), .if_error(if_error),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_error(ld_error), .busy(busy), .rom_address(rom_address),
    .rom_read_data(rom_read_data), .rom_illegal_address(rom_illegal_address)
  );

  // ---------------- reference model ----------------
  function automatic int exp_n(input bit is_ld, input logic [1:0] size);
    if (!is_ld) return 4;
    case (size)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] addr, input int n);
    logic [31:0] d = '0;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      if (a < 32'd4096) d = d | (32'(mem[a[11:0]]) << (8*i));
    end
    return d;
  endfunction

  function automatic logic exp_err(input bit is_ld, input logic [1:0] size,
                                   input logic [31:0] addr, input int n);
    logic [31:0] a;
    if (is_ld && size == 2'd3) return 1'b1;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      if (a >= 32'd4096) return 1'b1;
    end
    return 1'b0;
  endfunction

  // ---------------- driver (observes, does not judge) ----------------
  task automatic run_one(input bit is_ld, input logic [31:0] addr, input logic [1:0] size,
                         output int lat, output logic [31:0] data, output logic err,
                         output logic wrong_port, output logic [31:0] addrs [0:7],
                         output logic busy_ok);
    lat = -1; data = '0; err = 1'b0; wrong_port = 1'b0; busy_ok = 1'b1;
    for (int i = 0; i < 8; i++) addrs[i] = '0;
    @(negedge clk);
    if (is_ld) begin ld_req = 1'b1; ld_addr = addr; ld_size = size; end
    else begin if_req = 1'b1; if_addr = addr; end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c < 8) addrs[c] = rom_address;
      if (!busy) busy_ok = 1'b0;
      if (is_ld ? if_ready : ld_ready) wrong_port = 1'b1;
      if (is_ld ? ld_ready : if_ready) begin
        lat  = c;
        data = is_ld ? ld_data : if_data;
        err  = is_ld ? ld_error : if_error;
        break;
      end
    end
    if_req = 1'b0;
    ld_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (if_ready !== 1'b0 || ld_ready !== 1'b0) begin n_fail++;
      $display("FAIL reset_ready: if_ready=%b ld_ready=%b want 0 0", if_ready, ld_ready); end
    n_checks++; if (if_error !== 1'b0 || ld_error !== 1'b0) begin n_fail++;
      $display("FAIL reset_error: if_error=%b ld_error=%b want 0 0", if_error, ld_error); end
    n_checks++; if (if_data !== 32'h0 || ld_data !== 32'h0) begin n_fail++;
      $display("FAIL reset_data: if_data=%h ld_data=%h want 0 0", if_data, ld_data); end
    n_checks++; if (busy !== 1'b0 || rom_address !== 32'h0) begin n_fail++;
      $display("FAIL reset_busy_addr: busy=%b rom_address=%h want 0 0", busy, rom_address); end
    reset = 1'b0;
  endtask

  task automatic test_fetch_basic();
    int lat; logic [31:0] d; logic e, wp, bok; logic [31:0] ad [0:7];
    mem[12'h010] = 8'h13; mem[12'h011] = 8'h05; mem[12'h012] = 8'h50; mem[12'h013] = 8'h00;
    run_one(1'b0, 32'h10, 2'd0, lat, d, e, wp, ad, bok);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL fetch_latency: got %0d want 5", lat); end
    n_checks++; if (d !== 32'h00500513) begin n_fail++; $display("FAIL fetch_data: got %h want 00500513", d); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL fetch_error: got %b want 0", e); end
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (ad[c] !== 32'h10 + 32'(c - 1)) begin n_fail++;
        $display("FAIL fetch_rom_address[%0d]: got %h want %h", c, ad[c], 32'h10 + 32'(c - 1)); end
    end
    n_checks++; if (wp !== 1'b0 || bok !== 1'b1) begin n_fail++;
      $display("FAIL fetch_port_busy: wrong_port=%b busy_ok=%b want 0 1", wp, bok); end
    @(negedge clk);
    n_checks++; if (if_data !== 32'h00500513 || busy !== 1'b0 || if_ready !== 1'b0) begin n_fail++;
      $display("FAIL fetch_hold: if_data=%h busy=%b if_ready=%b want 00500513 0 0", if_data, busy, if_ready); end
  endtask

  task automatic test_load_sizes();
    int lat; logic [31:0] d; logic e, wp, bok; logic [31:0] ad [0:7];
    mem[12'h021] = 8'hAB; mem[12'h022] = 8'hCD;
    run_one(1'b1, 32'h21, 2'd0, lat, d, e, wp, ad, bok);
    n_checks++; if (lat !== 2 || d !== 32'h000000AB || e !== 1'b0) begin n_fail++;
      $display("FAIL load_byte: lat=%0d data=%h err=%b want 2 000000ab 0", lat, d, e); end
    run_one(1'b1, 32'h21, 2'd1, lat, d, e, wp, ad, bok);
    n_checks++; if (lat !== 3 || d !== 32'h0000CDAB || e !== 1'b0) begin n_fail++;
      $display("FAIL load_half: lat=%0d data=%h err=%b want 3 0000cdab 0", lat, d, e); end
    run_one(1'b1, 32'h21, 2'd2, lat, d, e, wp, ad, bok);
    n_checks++; if (lat !== 5 || d !== exp_data(32'h21, 4) || wp !== 1'b0) begin n_fail++;
      $display("FAIL load_word: lat=%0d data=%h wrong_port=%b want 5 %h 0", lat, d, wp, exp_data(32'h21, 4)); end
  endtask

  task automatic test_rom_end();
    int lat; logic [31:0] d; logic e, wp, bok; logic [31:0] ad [0:7];
    run_one(1'b0, 32'hFFE, 2'd0, lat, d, e, wp, ad, bok);
    n_checks++; if (lat !== 5 || e !== 1'b1) begin n_fail++;
      $display("FAIL rom_end_error: lat=%0d err=%b want 5 1", lat, e); end
    n_checks++; if (d !== {16'h0, mem[12'hFFF], mem[12'hFFE]}) begin n_fail++;
      $display("FAIL rom_end_data: got %h want %h", d, {16'h0, mem[12'hFFF], mem[12'hFFE]}); end
    n_checks++; if (ad[3] !== 32'h1000 || ad[4] !== 32'h1001) begin n_fail++;
      $display("FAIL rom_end_addr: got %h %h want 00001000 00001001", ad[3], ad[4]); end
  endtask

  task automatic test_illegal_size();
    int lat; logic [31:0] d; logic e, wp, bok; logic [31:0] ad [0:7];
    run_one(1'b1, 32'h40, 2'd2, lat, d, e, wp, ad, bok);
    run_one(1'b1, 32'h40, 2'd3, lat, d, e, wp, ad, bok);
    n_checks++; if (lat !== 1 || e !== 1'b1) begin n_fail++;
      $display("FAIL illegal_size: lat=%0d err=%b want 1 1", lat, e); end
    n_checks++; if (d !== 32'h0 || ad[1] !== 32'h0) begin n_fail++;
      $display("FAIL illegal_size_data: data=%h rom_address=%h want 0 0", d, ad[1]); end
  endtask

  task automatic test_back_to_back();
    int got_cyc [$]; bit got_ld [$];
    int t; bit last_ld; bit g_ld; bit both_seen;
    do_reset();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    ld_req = 1'b1; ld_addr = 32'h200; ld_size = 2'd2;
    both_seen = 1'b0;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      if (if_ready && ld_ready) both_seen = 1'b1;
      if (if_ready) begin got_cyc.push_back(c); got_ld.push_back(1'b0);
        n_checks++; if (if_data !== exp_data(32'h100, 4)) begin n_fail++;
          $display("FAIL rr_fetch_data: got %h want %h", if_data, exp_data(32'h100, 4)); end
      end
      if (ld_ready) begin got_cyc.push_back(c); got_ld.push_back(1'b1);
        n_checks++; if (ld_data !== exp_data(32'h200, 4)) begin n_fail++;
          $display("FAIL rr_load_data: got %h want %h", ld_data, exp_data(32'h200, 4)); end
      end
    end
    if_req = 1'b0; ld_req = 1'b0;
    n_checks++; if (got_cyc.size() !== 4 || both_seen) begin n_fail++;
      $display("FAIL rr_count: got %0d ready pulses (overlap=%b) want 4 (0)", got_cyc.size(), both_seen); end
    t = 0; last_ld = 1'b1;
    for (int k = 0; k < 4 && k < got_cyc.size(); k++) begin
      g_ld = ~last_ld;
      n_checks++;
      if (got_cyc[k] !== t + 5 || got_ld[k] !== g_ld) begin n_fail++;
        $display("FAIL rr_order[%0d]: cycle %0d port_ld %b want cycle %0d port_ld %b", k, got_cyc[k], got_ld[k], t + 5, g_ld); end
      t = t + 6; last_ld = g_ld;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int rdy_at; bit early;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h300;
    repeat (3) @(negedge clk);
    n_checks++; if (rom_address !== 32'h302) begin n_fail++;
      $display("FAIL mid_third_read: rom_address=%h want 00000302", rom_address); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (if_ready !== 1'b0 || busy !== 1'b0 || rom_address !== 32'h0 || if_data !== 32'h0 || if_error !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: ready=%b busy=%b addr=%h data=%h err=%b want all 0",
               if_ready, busy, rom_address, if_data, if_error);
    end
    @(negedge clk);
    early = if_ready;
    reset = 1'b0;
    rdy_at = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++; if (rom_address !== 32'h300) begin n_fail++;
          $display("FAIL mid_restart_addr: rom_address=%h want 00000300", rom_address); end
      end
      if (if_ready) begin rdy_at = k; break; end
    end
    if_req = 1'b0;
    n_checks++; if (rdy_at !== 5 || early !== 1'b0) begin n_fail++;
      $display("FAIL mid_restart_latency: ready after %0d (pulse during reset %b) want 5 (0)", rdy_at, early); end
    n_checks++; if (if_data !== exp_data(32'h300, 4)) begin n_fail++;
      $display("FAIL mid_restart_data: got %h want %h", if_data, exp_data(32'h300, 4)); end
  endtask

  task automatic test_random();
    int lat, n; logic [31:0] d; logic e, wp, bok; logic [31:0] ad [0:7];
    bit is_ld; logic [31:0] addr; logic [1:0] size;
    for (int t = 0; t < 40; t++) begin
      is_ld = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       addr = 32'($urandom_range(4092, 4095));
        1:       addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        default: addr = 32'($urandom_range(0, 4095));
      endcase
      n = exp_n(is_ld, size);
      run_one(is_ld, addr, size, lat, d, e, wp, ad, bok);
      n_checks++;
      if (lat !== n + 1 || d !== exp_data(addr, n) || e !== exp_err(is_ld, size, addr, n)) begin
        n_fail++;
        $display("FAIL rand[%0d] ld=%b addr=%h size=%0d: lat=%0d data=%h err=%b want %0d %h %b",
                 t, is_ld, addr, size, lat, d, e, n + 1, exp_data(addr, n), exp_err(is_ld, size, addr, n));
      end
      n_checks++;
      if (wp !== 1'b0 || bok !== 1'b1) begin n_fail++;
        $display("FAIL rand_port_busy[%0d]: wrong_port=%b busy_ok=%b want 0 1", t, wp, bok); end
      for (int c = 1; c <= n; c++) begin
        n_checks++;
        if (ad[c] !== addr + 32'(c - 1)) begin n_fail++;
          $display("FAIL rand_addr[%0d][%0d]: got %h want %h", t, c, ad[c], addr + 32'(c - 1)); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; ld_req = 1'b0;
    if_addr = '0; ld_addr = '0; ld_size = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    test_reset();
    test_fetch_basic();
    test_load_sizes();
    test_rom_end();
    test_illegal_size();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
